eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Ethernet transmit framer, the transmit-side counterpart of the receive CRC check. Accepts one frame's bytes (destination MAC through payload, no FCS) on a valid/ready stream. Emits preamble, SFD, data, zero padding to minimum length, the 4-byte FCS and the inter-frame gap as a byte stream. A downstream PHY serializer (GMII byte-wide, or RMII dibit) paces the output with a per-byte strobe.

## Interface
- `MIN_LEN`, default 60: minimum data+pad bytes before the FCS.
- `IFG_BYTES`, default 12: idle byte times after the FCS.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `s_data` in 8: frame byte.
- `s_valid` in 1: `s_data` valid.
- `s_last` in 1: this is the final frame byte.
- `s_ready` out 1: byte accepted this cycle when `s_valid & s_ready`.
- `tx_ready` in 1: strobe; the serializer consumes the current `txd` at this edge.
- `txd` out 8: output byte, registered.
- `tx_en` out 1: high while preamble, SFD, data, pad or FCS is on `txd`.
- `tx_err` out 1: high on the byte that flags an underrun.

## Operation
- The state names the byte currently on `txd`: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- All byte-to-byte transitions happen only on edges where `tx_ready`=1. The single exception is IDLE→PRE.
- **IDLE**: `tx_en`=0, `txd`=0. If `s_valid`=1, load `txd`=0x55 and go to PRE (`tx_ready` is not needed). The first byte is not consumed here.
- **PRE**: 7 bytes of 0x55 in total, then load 0xD5 and go to SFD. Loading the SFD resets the CRC to all-ones.
- **SFD / DATA (not last)**:
  - `s_ready` = `tx_ready` (combinational).
  - Accepted byte → `txd`, state DATA. Record `s_last`, feed the byte to the CRC, increment the byte count.
  - If `s_valid`=0 at a `tx_ready` edge, that is an underrun. Load `txd`=0x00, `tx_err`=1, `tx_en`=1 for one byte, then go to IFG. No FCS is sent.
- **DATA (last) / PAD**:
  - If count < `MIN_LEN`, load 0x00 into PAD, feed it to the CRC and increment the count.
  - Otherwise load FCS byte 0.
- **FCS**:
  - Byte k (k=0..3) = ~crc[8k+7:8k], least significant byte first.
  - The CRC is frozen during FCS. A 2-bit index selects the byte.
  - After byte 3, load 0 with `tx_en`=0 and go to IFG.
- **IFG**: `IFG_BYTES` byte times (counted in `tx_ready` strobes) with `tx_en`=0, then IDLE. A waiting `s_valid` is ignored until IDLE.
- **Byte counter**: 7 bits, saturating at 127. Only the compare against `MIN_LEN` matters. Frame length is otherwise unbounded.
- **CRC**: reflected CRC-32, register initialised to all-ones. It is updated on the same edge the byte is loaded into `txd`, so it is final before the next `tx_ready` edge.
- **Reset** (including mid-frame): state IDLE, `txd`=0, `tx_en`=0, `tx_err`=0, `s_ready`=0, counters 0. The partially sent frame is truncated with no FCS.

## Timing
- `s_valid` rising in IDLE at edge N puts the first 0x55 on `txd`/`tx_en` after edge N.
- Each output byte is held from its load edge until the next `tx_ready` edge.
- `s_ready` is combinational from state and `tx_ready`. There is no input buffering, so the source must present the next byte within the same strobe cycle.
- With `tx_ready` tied high, a frame of L ≥ 60 bytes occupies 8 + L + 4 `tx_en` cycles, followed by 12 idle cycles.

## Structure
- Shared package `eth_pkg`:
  - state enum `eth_tx_state_t`
  - `ETH_PREAMBLE`=8'h55, `ETH_SFD`=8'hD5
  - `ETH_MIN_LEN`=60, `ETH_IFG`=12
  - `ETH_CRC_RESIDUE`=32'hDEBB20E3
- Sub-module: the existing `eth_crc32_8`.
  - `en` = byte load into DATA/PAD.
  - `rst` = SFD-load strobe (synchronous, active-high).
  - `din` = loaded byte.
  - `crc` is the raw register.

## Test plan
- `tx_ready`=1, 64-byte frame of incrementing bytes → 7×0x55, 0xD5, 64 data bytes, 4 FCS bytes; CRC-32 over data+FCS yields the 0xDEBB20E3 residue.
- 14-byte frame → data followed by 46 bytes of 0x00; `tx_en` high for 8+60+4=72 cycles; residue correct.
- Same frames with `tx_ready` strobed every 4th cycle (RMII pace) → byte sequence identical to the `tx_ready`=1 case; `txd` stable between strobes.
- Back-to-back frames, `s_valid` held high → exactly 12 `tx_ready` strobes with `tx_en`=0 between the last FCS byte and the next 0x55.
- `s_valid` dropped after 5 data bytes → one 0x00 byte with `tx_err`=1, no FCS, then IFG, then IDLE.
- `rst_n` asserted mid-DATA → `tx_en`=0, `txd`=0 immediately (asynchronous); the next frame starts cleanly with a fresh preamble and correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit path.
// Holds the framer state encoding and the FCS byte selector.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_ERR
    } eth_tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam int          ETH_MIN_LEN     = 60;
    localparam int          ETH_IFG         = 12;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;

    // FCS goes out complemented, least significant byte first
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                            input logic [1:0]  idx);
        logic [31:0] s;
        s = ~crc >> {idx, 3'b000};
        return s[7:0];
    endfunction

endpackage

// File: rtl/eth_crc32_8.sv
// Byte-wide reflected CRC-32 register (poly 0xEDB88320).
// Synchronous clear to all-ones has priority over the update.
module eth_crc32_8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rst,
    input  logic [7:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (rst) begin
            crc_d = '1;
        end else if (en) begin
            crc_d = crc_q ^ {24'h0, din};
            for (int i = 0; i < 8; i++) begin
                crc_d = crc_d[0] ? ((crc_d >> 1) ^ ETH_CRC_POLY)
                                 : (crc_d >> 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '1;
        else        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, data, pad, FCS and IFG,
// paced one byte per tx_ready strobe from the PHY serializer.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_LEN   = ETH_MIN_LEN,
    parameter int IFG_BYTES = ETH_IFG
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       tx_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_err
);

    localparam logic [6:0] MIN_L    = 7'(MIN_LEN);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

    eth_tx_state_t state_q, state_d;
    logic [7:0]    txd_q, txd_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_err_q, tx_err_d;
    logic [2:0]    pre_q, pre_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [1:0]    fcs_q, fcs_d;
    logic [7:0]    ifg_q, ifg_d;

    logic          crc_en;
    logic          crc_rst;
    logic [7:0]    crc_din;
    logic [31:0]   crc;

    logic idle_st, pre_st, acc_st, cls_st;
    logic fcs_st, ifg_st, err_st;
    logic [6:0] cnt_inc;

    assign idle_st = (state_q == ST_IDLE);
    assign pre_st  = (state_q == ST_PRE);
    // SFD or non-final data on txd: next strobe takes a source byte
    assign acc_st  = (state_q == ST_SFD) ||
                     ((state_q == ST_DATA) && !last_q);
    assign cls_st  = ((state_q == ST_DATA) && last_q) ||
                     (state_q == ST_PAD);
    assign fcs_st  = (state_q == ST_FCS);
    assign ifg_st  = (state_q == ST_IFG);
    assign err_st  = (state_q == ST_ERR);
    assign cnt_inc = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;

    assign s_ready = tx_ready && acc_st;

    always_comb begin
        state_d  = state_q;
        txd_d    = txd_q;
        tx_en_d  = tx_en_q;
        tx_err_d = tx_err_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        fcs_d    = fcs_q;
        ifg_d    = ifg_q;
        crc_en   = 1'b0;
        crc_rst  = 1'b0;
        crc_din  = 8'h00;
        unique case (1'b1)
            idle_st: begin
                txd_d    = 8'h00;
                tx_en_d  = 1'b0;
                tx_err_d = 1'b0;
                if (s_valid) begin
                    state_d = ST_PRE;
                    txd_d   = ETH_PREAMBLE;
                    tx_en_d = 1'b1;
                    pre_d   = 3'd0;
                end
            end
            pre_st: if (tx_ready) begin
                if (pre_q == 3'd6) begin
                    state_d = ST_SFD;
                    txd_d   = ETH_SFD;
                    crc_rst = 1'b1;
                    cnt_d   = 7'd0;
                    last_d  = 1'b0;
                end else begin
                    pre_d = pre_q + 3'd1;
                end
            end
            acc_st: if (tx_ready) begin
                if (s_valid) begin
                    state_d = ST_DATA;
                    txd_d   = s_data;
                    last_d  = s_last;
                    crc_en  = 1'b1;
                    crc_din = s_data;
                    cnt_d   = cnt_inc;
                end else begin
                    state_d  = ST_ERR;
                    txd_d    = 8'h00;
                    tx_err_d = 1'b1;
                end
            end
            cls_st: if (tx_ready) begin
                if (cnt_q < MIN_L) begin
                    state_d = ST_PAD;
                    txd_d   = 8'h00;
                    crc_en  = 1'b1;
                    cnt_d   = cnt_inc;
                end else begin
                    state_d = ST_FCS;
                    txd_d   = fcs_byte(crc, 2'd0);
                    fcs_d   = 2'd0;
                end
            end
            fcs_st: if (tx_ready) begin
                if (fcs_q == 2'd3) begin
                    state_d = ST_IFG;
                    txd_d   = 8'h00;
                    tx_en_d = 1'b0;
                    ifg_d   = 8'd0;
                end else begin
                    fcs_d = fcs_q + 2'd1;
                    txd_d = fcs_byte(crc, fcs_q + 2'd1);
                end
            end
            ifg_st: if (tx_ready) begin
                if (ifg_q == IFG_LAST) state_d = ST_IDLE;
                else                   ifg_d   = ifg_q + 8'd1;
            end
            err_st: if (tx_ready) begin
                state_d  = ST_IFG;
                txd_d    = 8'h00;
                tx_en_d  = 1'b0;
                tx_err_d = 1'b0;
                ifg_d    = 8'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            txd_q    <= 8'h00;
            tx_en_q  <= 1'b0;
            tx_err_q <= 1'b0;
            pre_q    <= 3'd0;
            cnt_q    <= 7'd0;
            last_q   <= 1'b0;
            fcs_q    <= 2'd0;
            ifg_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            txd_q    <= txd_d;
            tx_en_q  <= tx_en_d;
            tx_err_q <= tx_err_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            fcs_q    <= fcs_d;
            ifg_q    <= ifg_d;
        end
    end

    eth_crc32_8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (crc_en),
        .rst   (crc_rst),
        .din   (crc_din),
        .crc   (crc)
    );

    assign txd    = txd_q;
    assign tx_en  = tx_en_q;
    assign tx_err = tx_err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: captures every strobed byte
// and checks framing, padding, FCS, IFG, underrun and reset.
module tb_eth_tx_framer;
    import eth_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       tx_ready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_d[$];
    logic       src_l[$];
    int         ptr;
    int         stop;
    int         pace;
    int         cyc;
    logic [9:0] cap[$];
    logic [7:0] fr_q[$];
    logic [7:0] ref_a[$];
    logic [7:0] ref_b[$];
    int         fr_errs;
    int         fr_end;
    int         pre_ok;
    int         pstart;
    int         stab_bad;
    logic [7:0] prev_txd;
    logic       prev_rdy;
    logic       prev_en;

    always #5 clk = ~clk;

    eth_tx_framer #(.MIN_LEN(60), .IFG_BYTES(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_en    (tx_en),
        .tx_err   (tx_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (q[i]) begin
            r = r ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++)
                r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic drive_src();
        if (ptr < src_d.size() && ptr < stop) begin
            s_valid = 1'b1;
            s_data  = src_d[ptr];
            s_last  = src_l[ptr];
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
            s_last  = 1'b0;
        end
    endtask

    task automatic clear_src();
        src_d.delete();
        src_l.delete();
        ptr  = 0;
        stop = 1 << 30;
        drive_src();
    endtask

    task automatic add_frame(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            src_d.push_back(base + 8'(i));
            src_l.push_back(i == len - 1);
        end
        drive_src();
    endtask

    // One clock: capture on the falling edge, drive 1ns after rising
    task automatic tick();
        logic hs;
        @(negedge clk);
        if (tx_ready) cap.push_back({tx_en, tx_err, txd});
        if (!prev_rdy && prev_en && txd !== prev_txd) stab_bad++;
        prev_rdy = tx_ready;
        prev_en  = tx_en;
        prev_txd = txd;
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) ptr++;
        cyc++;
        tx_ready = (pace == 1) || (cyc % 4 == 0);
        drive_src();
    endtask

    task automatic run(input string tag, input int drain);
        int c;
        c = 0;
        while (ptr < src_d.size() && ptr < stop && c < 4000) begin
            tick();
            c++;
        end
        chk(tag, 32'(c < 4000), 1);
        repeat (drain) tick();
    endtask

    task automatic parse(input int start);
        int p;
        p = start;
        fr_q.delete();
        fr_errs = 0;
        pre_ok  = 1;
        while (p < cap.size() && !cap[p][9]) p++;
        for (int i = 0; i < 8; i++) begin
            if (p >= cap.size() ||
                cap[p] !== {2'b10, (i == 7) ? 8'hD5 : 8'h55})
                pre_ok = 0;
            p++;
        end
        while (p < cap.size() && cap[p][9]) begin
            fr_q.push_back(cap[p][7:0]);
            if (cap[p][8]) fr_errs++;
            p++;
        end
        fr_end = p;
    endtask

    function automatic int gap_from(input int start);
        int g;
        int p;
        g = 0;
        p = start;
        while (p < cap.size() && !cap[p][9]) begin
            g++;
            p++;
        end
        return g;
    endfunction

    function automatic int count_en();
        int n;
        n = 0;
        foreach (cap[i]) if (cap[i][9]) n++;
        return n;
    endfunction

    task automatic check_frame(input string tag, input int len,
                               input logic [7:0] base);
        logic [7:0]  e[$];
        logic [31:0] c;
        int          bad;
        bad = 0;
        for (int i = 0; i < len; i++) e.push_back(base + 8'(i));
        while (e.size() < 60) e.push_back(8'h00);
        c = ~crc_of(e);
        for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        parse(pstart);
        chk({tag, "_pre"}, 32'(pre_ok), 1);
        chk({tag, "_len"}, 32'(fr_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < fr_q.size(); i++)
            if (fr_q[i] !== e[i]) bad++;
        chk({tag, "_bytes"}, 32'(bad), 0);
        chk({tag, "_resid"}, crc_of(fr_q), ETH_CRC_RESIDUE);
        chk({tag, "_err"}, 32'(fr_errs), 0);
        pstart = fr_end;
    endtask

    task automatic same_as(input string tag, input logic [7:0] r[$]);
        int bad;
        bad = 0;
        chk({tag, "_size"}, 32'(fr_q.size()), 32'(r.size()));
        for (int i = 0; i < r.size() && i < fr_q.size(); i++)
            if (fr_q[i] !== r[i]) bad++;
        chk({tag, "_same"}, 32'(bad), 0);
    endtask

    task automatic new_test(input int p);
        pace     = p;
        cap.delete();
        pstart   = 0;
        stab_bad = 0;
        clear_src();
    endtask

    initial begin
        int c;
        pace     = 1;
        cyc      = 0;
        tx_ready = 1'b1;
        rst_n    = 1'b0;
        prev_rdy = 1'b1;
        prev_en  = 1'b0;
        prev_txd = 8'h00;
        stab_bad = 0;
        clear_src();
        repeat (3) tick();
        chk("rst_txd", 32'(txd), 0);
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_tx_err", 32'(tx_err), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 64-byte frame, byte-wide pace
        new_test(1);
        add_frame(64, 8'h00);
        run("A_run", 40);
        check_frame("A", 64, 8'h00);
        chk("A_en_cycles", 32'(count_en()), 76);
        ref_a = fr_q;

        // 14-byte frame padded to 60
        new_test(1);
        add_frame(14, 8'hA0);
        run("B_run", 80);
        check_frame("B", 14, 8'hA0);
        chk("B_en_cycles", 32'(count_en()), 72);
        ref_b = fr_q;

        // Same frames at one strobe every 4 clocks
        new_test(4);
        add_frame(64, 8'h00);
        run("A4_run", 120);
        check_frame("A4", 64, 8'h00);
        same_as("A4", ref_a);
        chk("A4_stable", 32'(stab_bad), 0);

        new_test(4);
        add_frame(14, 8'hA0);
        run("B4_run", 300);
        check_frame("B4", 14, 8'hA0);
        same_as("B4", ref_b);
        chk("B4_stable", 32'(stab_bad), 0);

        // Back-to-back, s_valid never drops: IFG counted in strobes
        new_test(4);
        add_frame(20, 8'h10);
        add_frame(60, 8'h40);
        run("BB_run", 300);
        check_frame("BB1", 20, 8'h10);
        chk("BB_gap_strobes", 32'(gap_from(pstart)), 12);
        check_frame("BB2", 60, 8'h40);

        // Underrun after 5 bytes; next frame is already waiting
        new_test(1);
        add_frame(20, 8'h80);
        stop = 5;
        run("U_run", 1);
        clear_src();
        add_frame(14, 8'hC0);
        run("U2_run", 80);
        parse(0);
        chk("U_pre", 32'(pre_ok), 1);
        chk("U_len", 32'(fr_q.size()), 6);
        c = 0;
        for (int i = 0; i < 5 && i < fr_q.size(); i++)
            if (fr_q[i] !== 8'h80 + 8'(i)) c++;
        chk("U_data", 32'(c), 0);
        chk("U_errbyte", 32'(cap[fr_end - 1]), 32'h300);
        chk("U_errcount", 32'(fr_errs), 1);
        // 12 IFG byte times plus the one IDLE cycle that sees s_valid
        chk("U_gap", 32'(gap_from(fr_end)), 13);
        pstart = fr_end;
        check_frame("U_next", 14, 8'hC0);

        // Asynchronous reset in the middle of the data phase
        new_test(1);
        add_frame(64, 8'h20);
        c = 0;
        while (ptr < 10 && c < 200) begin
            tick();
            c++;
        end
        chk("R_reach_data", 32'(c < 200), 1);
        chk("R_pre_en", 32'(tx_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("R_txd", 32'(txd), 0);
        chk("R_tx_en", 32'(tx_en), 0);
        chk("R_s_ready", 32'(s_ready), 0);
        clear_src();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        new_test(1);
        add_frame(64, 8'h20);
        run("R_run", 40);
        check_frame("R", 64, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
